// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Sequences four single-line pixel buffers into a rolling 3-row window.
// Incoming pixels fill one buffer per line, rotating through all four. Once
// three full lines are stored, a row pass reads the three oldest buffers in
// lockstep and presents their taps as {top,mid,bot}. The fourth buffer keeps
// taking writes during the pass.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (also forwarded as lb_rst)
//   pixel        incoming 8-bit pixel
//   pixel_valid  pixel present; taken when pixel_valid && in_ready
//   in_ready     room for another pixel (occupancy below four lines)
//   lb_rst       reset to the four line buffers
//   lb_pixel     pixel forwarded to the buffers
//   lb_wr_en     one-hot write strobe to the buffer being filled
//   lb_rd_en     read-advance strobes to the three buffers being read
//   lb_data0..3  24-bit tap outputs of buffers 0..3
//   window       {top,mid,bot} taps, top = oldest line
//   out_valid    window valid
//   out_ready    downstream accepts the window
//   line_done    one-cycle pulse after the last window of a row pass
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter int IMG_WIDTH = 640,
    parameter int CNT_W     = $clog2(4 * IMG_WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel,
    input  logic        pixel_valid,
    output logic        in_ready,
    output logic        lb_rst,
    output logic [7:0]  lb_pixel,
    output logic [3:0]  lb_wr_en,
    output logic [3:0]  lb_rd_en,
    input  logic [23:0] lb_data0,
    input  logic [23:0] lb_data1,
    input  logic [23:0] lb_data2,
    input  logic [23:0] lb_data3,
    output logic [71:0] window,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        line_done
);

    localparam int LINE_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0]  OCC_FULL  = CNT_W'(4 * IMG_WIDTH);
    localparam logic [CNT_W-1:0]  OCC_START = CNT_W'(3 * IMG_WIDTH);
    localparam logic [CNT_W-1:0]  OCC_LINE  = CNT_W'(IMG_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         wr_sel_r;
    logic [1:0]         rd_sel_r;
    logic [LINE_W-1:0]  wr_cnt_r;
    logic [LINE_W-1:0]  rd_cnt_r;
    logic [CNT_W-1:0]   occ_r;
    logic [CNT_W-1:0]   occ_nxt_s;
    logic               line_done_r;
    logic               accept_s;
    logic               hs_s;
    logic               rd_last_s;
    logic               wr_last_s;
    logic [3:0]         rd_mask_s;
    logic [23:0]        taps_s [4];
    logic [1:0]         mid_sel_s;
    logic [1:0]         bot_sel_s;

    // Handshake qualifiers; reset blocks any transfer in the reset cycle itself.
    assign in_ready  = rst ? 1'b1 : (occ_r < OCC_FULL);
    assign accept_s  = pixel_valid && in_ready && !rst;
    assign hs_s      = out_valid && out_ready;
    assign rd_last_s = hs_s && (rd_cnt_r == LINE_LAST);
    assign wr_last_s = accept_s && (wr_cnt_r == LINE_LAST);

    assign lb_rst    = rst;
    assign lb_pixel  = pixel;
    assign lb_wr_en  = accept_s ? (4'b0001 << wr_sel_r) : 4'b0000;
    assign line_done = line_done_r && !rst;

    // Window mux: the 2-bit select arithmetic wraps mod 4 on its own.
    assign taps_s[0] = lb_data0;
    assign taps_s[1] = lb_data1;
    assign taps_s[2] = lb_data2;
    assign taps_s[3] = lb_data3;
    assign mid_sel_s = rd_sel_r + 2'd1;
    assign bot_sel_s = rd_sel_r + 2'd2;
    assign window    = {taps_s[rd_sel_r], taps_s[mid_sel_s], taps_s[bot_sel_s]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: start a pass on registered occupancy, end it on the last read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (occ_r >= OCC_START) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: valid window in READ, read strobes to the three oldest buffers.
    always_comb begin
        out_valid = 1'b0;
        rd_mask_s = 4'b0000;
        case (state_r)
            ST_READ: out_valid = !rst;
            ST_IDLE: out_valid = 1'b0;
            default: out_valid = 1'b0;
        endcase
        case (rd_sel_r)
            2'd0:    rd_mask_s = 4'b0111;
            2'd1:    rd_mask_s = 4'b1110;
            2'd2:    rd_mask_s = 4'b1101;
            2'd3:    rd_mask_s = 4'b1011;
            default: rd_mask_s = 4'b0000;
        endcase
        if (hs_s) begin
            lb_rd_en = rd_mask_s;
        end else begin
            lb_rd_en = 4'b0000;
        end
    end

    // Occupancy next value: add a pixel per accept, release a line per finished pass.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({accept_s, rd_last_s})
            2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_LINE;
            2'b11:   occ_nxt_s = occ_r - OCC_LINE + CNT_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Write side: pixel counter within the line and the buffer being filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r <= {LINE_W{1'b0}};
            wr_sel_r <= 2'd0;
        end else if (wr_last_s) begin
            wr_cnt_r <= {LINE_W{1'b0}};
            wr_sel_r <= wr_sel_r + 2'd1;
        end else if (accept_s) begin
            wr_cnt_r <= wr_cnt_r + LINE_W'(1);
        end
    end

    // Read side: window counter within the pass, oldest-line pointer, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_r    <= {LINE_W{1'b0}};
            rd_sel_r    <= 2'd0;
            line_done_r <= 1'b0;
        end else begin
            line_done_r <= rd_last_s;
            if (rd_last_s) begin
                rd_cnt_r <= {LINE_W{1'b0}};
                rd_sel_r <= rd_sel_r + 2'd1;
            end else if (hs_s) begin
                rd_cnt_r <= rd_cnt_r + LINE_W'(1);
            end
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= {CNT_W{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
// Randomized bench for line_buffer_ctrl with IMG_WIDTH=8. The reference keeps
// only totals: pixels accepted, lines consumed, position inside the current
// pass and occupancy. Buffer indices are derived arithmetically from those
// totals (fill buffer = (accepted / W) mod 4, top buffer = lines read mod 4).
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pixel = 8'h00;
    logic        pixel_valid = 1'b0;
    logic        in_ready;
    logic        lb_rst;
    logic [7:0]  lb_pixel;
    logic [3:0]  lb_wr_en;
    logic [3:0]  lb_rd_en;
    logic [23:0] lb_data0 = 24'h0;
    logic [23:0] lb_data1 = 24'h0;
    logic [23:0] lb_data2 = 24'h0;
    logic [23:0] lb_data3 = 24'h0;
    logic [71:0] window;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        line_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int acc_total  = 0;
    int lines_read = 0;
    int rd_pos     = 0;
    int occ_m      = 0;
    bit reading    = 1'b0;
    bit done_pend  = 1'b0;

    line_buffer_ctrl #(.IMG_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .pixel(pixel), .pixel_valid(pixel_valid),
        .in_ready(in_ready), .lb_rst(lb_rst), .lb_pixel(lb_pixel),
        .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
        .lb_data0(lb_data0), .lb_data1(lb_data1), .lb_data2(lb_data2), .lb_data3(lb_data3),
        .window(window), .out_valid(out_valid), .out_ready(out_ready), .line_done(line_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the reference, advance it.
    task automatic step(input bit r, input bit pv, input bit ordy);
        logic [3:0]  wr_e;
        logic [3:0]  rd_e;
        logic [23:0] d [4];
        bit ir_e, acc, hs, start;
        int top;
        @(posedge clk);
        #1;
        rst         = r;
        pixel_valid = pv;
        pixel       = 8'($urandom);
        out_ready   = ordy;
        lb_data0    = 24'($urandom);
        lb_data1    = 24'($urandom);
        lb_data2    = 24'($urandom);
        lb_data3    = 24'($urandom);
        @(negedge clk);
        d[0] = lb_data0; d[1] = lb_data1; d[2] = lb_data2; d[3] = lb_data3;
        top  = lines_read % 4;
        ir_e = r ? 1'b1 : (occ_m < 4 * W);
        acc  = pv && ir_e && !r;
        hs   = reading && ordy && !r;
        wr_e = acc ? 4'(1 << ((acc_total / W) % 4)) : 4'b0000;
        rd_e = 4'b0000;
        if (hs) begin
            for (int k = 0; k < 3; k++) rd_e[(top + k) % 4] = 1'b1;
        end
        check_val("in_ready",  72'(in_ready),  72'(ir_e));
        check_val("lb_wr_en",  72'(lb_wr_en),  72'(wr_e));
        check_val("lb_rd_en",  72'(lb_rd_en),  72'(rd_e));
        check_val("out_valid", 72'(out_valid), 72'(reading && !r));
        check_val("line_done", 72'(line_done), 72'(done_pend && !r));
        check_val("lb_rst",    72'(lb_rst),    72'(r));
        check_val("lb_pixel",  72'(lb_pixel),  72'(pixel));
        if (reading && !r) begin
            check_val("window", window, {d[top], d[(top + 1) % 4], d[(top + 2) % 4]});
        end
        if (r) begin
            acc_total = 0; lines_read = 0; rd_pos = 0; occ_m = 0;
            reading = 1'b0; done_pend = 1'b0;
        end else begin
            start     = !reading && (occ_m >= 3 * W);
            done_pend = 1'b0;
            if (acc) begin
                acc_total++;
                occ_m++;
            end
            if (hs) begin
                rd_pos++;
                if (rd_pos == W) begin
                    rd_pos = 0;
                    lines_read++;
                    occ_m -= W;
                    reading   = 1'b0;
                    done_pend = 1'b1;
                end
            end
            if (start) reading = 1'b1;
        end
    endtask

    initial begin
        bit reached;
        // Reset
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        // Fill three lines, then drain one pass with out_ready held high
        for (int i = 0; i < 3 * W; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 1'b1);
        // Backpressure: fill to capacity, extra pixels must be refused
        for (int i = 0; i < 5 * W; i++) step(1'b0, 1'b1, 1'b0);
        // Stall/resume toggling on out_ready
        for (int i = 0; i < 3 * W; i++) step(1'b0, 1'b0, 1'(i % 2));
        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end
        // Reset in the middle of a pass at window 4
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (reading && rd_pos == 4) reached = 1'b1;
            else step(1'b0, 1'b1, 1'b1);
        end
        check_val("reach_rd_cnt4", 72'(reached), 72'(1'b1));
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Refill replay
        for (int i = 0; i < 3 * W; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 1'b1);
        // Final read handshake coinciding with an accept at occupancy 3 lines
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3 * W; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4 * W; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4 * W; i++) step(1'b0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
